// File: rtl/core_pkg.sv
// Shared core definitions: default widths, fetch constants and the fetch entry record.
package core_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential fetch stride in bytes.
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush, zero-latency head and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flush wins over push and pop; popping an empty FIFO is ignored.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // Pointer and count state; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Entry storage needs no reset: an entry is only read after it is written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch PC owner: issues sequential word fetches, buffers in-order responses,
// hands {pc, instr} to decode and discards stale responses after a redirect.
//
// Handshakes: a transfer happens on a channel in every cycle where its valid and
// ready are both high at the rising edge; valid never waits for ready. The
// response channel has no ready: every imem_resp_valid cycle is a transfer.
module fetch_prefetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              ILEN     = DEF_ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [ILEN-1:0]            imem_resp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ILEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = CW + 2;
  localparam int EW = XLEN + ILEN;

  logic            r_run;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_live_cnt;
  logic [CW-1:0]   r_drop_cnt;

  logic            w_req_fire;
  logic            w_resp_fire;
  logic            w_resp_stale;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_tgt;
  logic [OW-1:0]   w_occupancy;
  logic [CW-1:0]   w_live_nxt;
  logic [CW-1:0]   w_drop_nxt;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [EW-1:0]   w_head;

  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign w_resp_fire    = imem_resp_valid;
  assign w_resp_stale   = w_resp_fire & (r_drop_cnt != '0);
  // A response landing in a redirect cycle belongs to the old stream.
  assign w_push         = w_resp_fire & ~w_resp_stale & ~redirect_valid;
  assign w_pop          = out_valid & out_ready;
  assign w_redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit: buffered plus every outstanding request (live or stale) stays within DEPTH,
  // so every response has a FIFO slot waiting for it.
  assign w_occupancy    = OW'(w_fifo_count) + OW'(r_live_cnt) + OW'(r_drop_cnt);
  assign imem_req_valid = r_run & (w_occupancy < OW'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign inflight       = r_live_cnt + r_drop_cnt;

  assign out_valid = ~w_fifo_empty & ~redirect_valid;
  assign out_pc    = w_head[EW-1:ILEN];
  assign out_instr = w_fifo_empty ? ILEN'(NOP_INSTR) : w_head[ILEN-1:0];

  // Outstanding-request bookkeeping; a redirect turns every live request stale.
  always_comb begin
    w_live_nxt = r_live_cnt;
    w_drop_nxt = r_drop_cnt;
    if (redirect_valid) begin
      w_live_nxt = '0;
      w_drop_nxt = r_drop_cnt + r_live_cnt + CW'(w_req_fire) - CW'(w_resp_fire);
    end else begin
      w_live_nxt = r_live_cnt + CW'(w_req_fire) - CW'(w_resp_fire & ~w_resp_stale);
      w_drop_nxt = r_drop_cnt - CW'(w_resp_stale);
    end
  end

  // PC and counter registers; fetching starts one cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_live_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_run      <= 1'b1;
      r_live_cnt <= w_live_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_tgt;
        r_resp_pc  <= w_redirect_tgt;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
        if (w_push)     r_resp_pc  <= r_resp_pc + XLEN'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data ({r_resp_pc, imem_resp_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // A response always matches an outstanding request, and the credit cap holds.
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_resp_fire && r_live_cnt == '0 && r_drop_cnt == '0));
  a_credit_cap: assert property (@(posedge clk) disable iff (!reset_n)
    w_occupancy <= OW'(DEPTH));
  a_push_has_room: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && w_fifo_full && !w_pop));

endmodule
